query_cmd_tx: RTL and testbench
===============================

Name: query_cmd_tx

Overview:
Builds and serialises EPC Gen2 inventory commands (Query, QueryRep, QueryAdjust) into a bitstream for the downstream PIE symbol encoder. For Query it computes the CRC-5 over the 17 payload bits with the team's CRC-5 rule and appends it to the frame. Command fields are latched on a start strobe. Bits go out MSB-first over a valid/ready handshake. The block sits between the inventory-round controller and the PIE modulator.

Parameters:
CRC_PRESET  5'b01001  CRC-5 register preset (polynomial x^5+x^3+1)
MAX_BITS  22  longest frame length (Query); sizes the shift register and bit counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request; samples cmd and field inputs
cmd  in  2  00=Query, 01=QueryRep, 10=QueryAdjust, 11=reserved
dr  in  1  Query DR field
m  in  2  Query M field
trext  in  1  Query TRext field
sel  in  2  Query Sel field
session  in  2  session (all three commands)
target  in  1  Query Target field
q  in  4  Query Q field
updn  in  3  QueryAdjust UpDn field
out_dat  out  1  serial command bit
out_vld  out  1  out_dat valid
out_rdy  in  1  downstream accepts bit
out_last  out  1  marks final bit of the frame (qualified by out_vld)
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last bit is accepted
err  out  1  one-cycle pulse when start carries cmd=11

Behaviour:
- Reset values: out_dat=0, out_vld=0, out_last=0, busy=0, done=0, err=0. FSM goes to IDLE and the CRC register loads CRC_PRESET.
- FSM states: IDLE, PAYLOAD, CRC, DONE.
- IDLE:
  - start with a valid cmd: latch the frame into a MAX_BITS shift register, left-aligned, and set the bit count. Preset the CRC. Go to PAYLOAD.
  - busy, out_vld and the first bit are all registered and appear the cycle after start.
- Frame contents:
  - Query: 1000,dr,m,trext,sel,session,target,q. 17 payload bits followed by 5 CRC bits, 22 bits total.
  - QueryRep: 00,session. 4 bits, no CRC.
  - QueryAdjust: 1001,session,updn. 9 bits, no CRC.
- start with cmd=11 in IDLE: err pulses on the next cycle and the state stays IDLE.
- start while busy: ignored. Latched fields do not change.
- Handshake:
  - A bit transfers on a cycle where out_vld && out_rdy.
  - While out_vld=1 and out_rdy=0, out_dat and out_last hold stable.
  - out_vld never drops mid-frame.
  - Back-to-back transfers allow one bit per cycle.
- CRC update (Query only), on every PAYLOAD transfer:
  - inv = bit ^ crc[4]
  - crc <= {crc[3], crc[2]^inv, crc[1], crc[0], inv}
- PAYLOAD: after the last payload bit transfers:
  - Query: go to CRC. The CRC bits are presented on the next cycle, crc[4] first.
  - Otherwise: out_last is asserted on the final payload bit, and the state goes to DONE after it transfers.
- CRC state:
  - Shifts out 5 bits MSB-first.
  - The CRC register shifts left with zero fill on each transfer and is not updated by the polynomial.
  - out_last is asserted on the 5th bit.
- DONE: lasts one cycle. done=1, out_vld=0, busy=0. Returns to IDLE.
  - A start arriving in the DONE cycle is ignored.
  - A new frame may start from the following cycle.
- rst asserted mid-frame: abort at the next edge with no done pulse. Outputs return to reset values.
- Bit counter saturates to avoid wrap. Counter width is clog2(MAX_BITS+1).

Test Plan:
- Query with all fields 0, out_rdy held 1 → 22 bits 1000_0000000000000_10000 (CRC=5'b10000), out_last on bit 22, done pulses one cycle after bit 22; start to done is 24 cycles.
- Same frame fed through an independent crc5 checker (preset 01001) → residue 5'b00000 after 22 bits; repeat with dr=1, m=11, q=1111 against the golden model.
- QueryRep session=10 → bits 0010, out_last on bit 4, no CRC bits; QueryAdjust session=01, updn=110 → 100101110, 9 bits.
- Query with out_rdy toggling randomly (~50%) → identical 22-bit sequence, out_dat/out_last stable during every stall, out_vld never drops mid-frame.
- start with cmd=11 → err pulse, busy stays 0; start pulsed at bit 10 of a Query → frame unchanged.
- rst asserted at bit 12 of a Query → next cycle out_vld=0, busy=0, no done pulse; a fresh Query afterwards produces a correct CRC (preset reloaded).

Source files
------------

// File: rtl/query_cmd_tx.sv
// EPC Gen2 inventory command serialiser.
// Builds Query / QueryRep / QueryAdjust frames and shifts them out MSB-first
// over a valid/ready handshake. Query frames get a CRC-5 appended.
module query_cmd_tx #(
  parameter logic [4:0] CRC_PRESET = 5'b01001,
  parameter int         MAX_BITS   = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic       dr,
  input  logic [1:0] m,
  input  logic       trext,
  input  logic [1:0] sel,
  input  logic [1:0] session,
  input  logic       target,
  input  logic [3:0] q,
  input  logic [2:0] updn,
  output logic       out_dat,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_W = $clog2(MAX_BITS + 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC, DONE} state_t;

  state_t               state;
  logic [MAX_BITS-1:0]  sr;         // bits still to be presented after out_dat
  logic [CNT_W-1:0]     cnt;        // bits remaining in current section, incl. out_dat
  logic [4:0]           crc;
  logic                 is_query;

  logic                 xfer;
  logic                 inv;
  logic [4:0]           crc_next;
  logic [CNT_W-1:0]     cnt_dec;
  logic [MAX_BITS-1:0]  frame;
  logic [CNT_W-1:0]     frame_len;

  assign xfer     = out_vld & out_rdy;
  assign inv      = out_dat ^ crc[4];
  assign crc_next = {crc[3], crc[2] ^ inv, crc[1], crc[0], inv};
  // Saturate at zero so a stray decrement can never wrap the counter.
  assign cnt_dec  = (cnt == '0) ? cnt : cnt - CNT_W'(1);

  // Assemble the payload left-aligned in the shift register width.
  always_comb begin
    frame     = '0;
    frame_len = '0;
    case (cmd)
      2'b00: begin
        frame[MAX_BITS-1 -: 17] = {4'b1000, dr, m, trext, sel, session, target, q};
        frame_len               = CNT_W'(17);
      end
      2'b01: begin
        frame[MAX_BITS-1 -: 4] = {2'b00, session};
        frame_len              = CNT_W'(4);
      end
      2'b10: begin
        frame[MAX_BITS-1 -: 9] = {4'b1001, session, updn};
        frame_len              = CNT_W'(9);
      end
      default: begin
        frame     = '0;
        frame_len = '0;
      end
    endcase
  end

  // Frame sequencer: latch on start, shift payload, then CRC, then one DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      crc      <= CRC_PRESET;
      is_query <= 1'b0;
      out_dat  <= 1'b0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cmd == 2'b11) begin
              err <= 1'b1;
            end else begin
              sr       <= {frame[MAX_BITS-2:0], 1'b0};
              out_dat  <= frame[MAX_BITS-1];
              cnt      <= frame_len;
              crc      <= CRC_PRESET;
              is_query <= (cmd == 2'b00);
              out_vld  <= 1'b1;
              out_last <= 1'b0;
              busy     <= 1'b1;
              state    <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (xfer) begin
            if (is_query) crc <= crc_next;
            if (cnt <= CNT_W'(1)) begin
              if (is_query) begin
                // First CRC bit comes from the register value after the last payload update.
                out_dat  <= crc_next[4];
                cnt      <= CNT_W'(5);
                out_last <= 1'b0;
                state    <= CRC;
              end else begin
                out_dat  <= 1'b0;
                out_vld  <= 1'b0;
                out_last <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= DONE;
              end
            end else begin
              out_dat  <= sr[MAX_BITS-1];
              sr       <= {sr[MAX_BITS-2:0], 1'b0};
              cnt      <= cnt_dec;
              out_last <= !is_query && (cnt == CNT_W'(2));
            end
          end
        end

        CRC: begin
          if (xfer) begin
            crc <= {crc[3:0], 1'b0};
            if (cnt <= CNT_W'(1)) begin
              out_dat  <= 1'b0;
              out_vld  <= 1'b0;
              out_last <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              out_dat  <= crc[3];
              cnt      <= cnt_dec;
              out_last <= (cnt == CNT_W'(2));
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_query_cmd_tx.sv
// Directed bench for query_cmd_tx: frame contents, CRC, handshake, error and reset cases.
module tb_query_cmd_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] cmd;
  logic       dr;
  logic [1:0] m;
  logic       trext;
  logic [1:0] sel;
  logic [1:0] session;
  logic       target;
  logic [3:0] q;
  logic [2:0] updn;
  logic       out_dat;
  logic       out_vld;
  logic       out_rdy;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  query_cmd_tx dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .dr(dr), .m(m),
    .trext(trext), .sel(sel), .session(session), .target(target), .q(q),
    .updn(updn), .out_dat(out_dat), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Independent CRC-5 (x^5+x^3+1, preset 01001) over the top n bits of f, MSB first.
  function automatic logic [4:0] crc5_run(input logic [21:0] f, input int n);
    logic [4:0] c;
    logic       b;
    c = 5'b01001;
    for (int i = 0; i < n; i++) begin
      b = f[21-i] ^ c[4];
      c = {c[3], c[2] ^ b, c[1], c[0], b};
    end
    return c;
  endfunction

  task automatic clear_fields();
    dr = 0; m = 0; trext = 0; sel = 0; session = 0; target = 0; q = 0; updn = 0;
  endtask

  task automatic send_start(input logic [1:0] c);
    @(negedge clk);
    cmd   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records accepted bits and handshake statistics until done or the cycle budget runs out.
  task automatic capture(input bit rand_rdy, input int inj_bit,
                         output logic [31:0] bits, output int nbits,
                         output int last_idx, output int n_last,
                         output int stall_bad, output int vld_drop,
                         output int done_cyc);
    bit   prev_stall;
    logic prev_dat, prev_last;
    bit   injected;
    int   cyc;
    bits = 0; nbits = 0; last_idx = 0; n_last = 0; stall_bad = 0; vld_drop = 0;
    done_cyc = -1; prev_stall = 0; prev_dat = 0; prev_last = 0; injected = 0;
    cyc = 1;
    while (cyc < 200) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!out_vld) vld_drop++;
      if (prev_stall && (out_dat !== prev_dat || out_last !== prev_last)) stall_bad++;
      if (inj_bit != 0 && nbits + 1 == inj_bit && !injected) begin
        start = 1'b1; cmd = 2'b01; session = ~session; dr = ~dr; q = ~q;
        injected = 1;
      end else begin
        start = 1'b0;
      end
      out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_vld && out_rdy) begin
        bits = {bits[30:0], out_dat};
        nbits++;
        if (out_last) begin
          n_last++;
          last_idx = nbits;
        end
      end
      prev_stall = out_vld && !out_rdy;
      prev_dat   = out_dat;
      prev_last  = out_last;
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    out_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_dat !== 1'b0)  begin n_bad++; $display("FAIL reset_out_dat got=%b exp=0", out_dat); end
    n_cmp++; if (out_vld !== 1'b0)  begin n_bad++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_query_zero();
    logic [31:0] bits;
    int nb, li, nl, sb, vd, dc;
    logic [21:0] exp_f;
    exp_f = 22'b1000_0000000000000_10000;
    clear_fields();
    send_start(2'b00);
    n_cmp++; if (busy !== 1'b1 || out_vld !== 1'b1 || out_dat !== 1'b1) begin
      n_bad++; $display("FAIL qz_first_cycle got busy=%b vld=%b dat=%b exp 1 1 1", busy, out_vld, out_dat);
    end
    capture(0, 0, bits, nb, li, nl, sb, vd, dc);
    n_cmp++; if (nb !== 22) begin n_bad++; $display("FAIL qz_nbits got=%0d exp=22", nb); end
    n_cmp++; if (bits[21:0] !== exp_f) begin n_bad++; $display("FAIL qz_bits got=%b exp=%b", bits[21:0], exp_f); end
    n_cmp++; if (li !== 22 || nl !== 1) begin n_bad++; $display("FAIL qz_last got idx=%0d cnt=%0d exp idx=22 cnt=1", li, nl); end
    n_cmp++; if (dc !== 23) begin n_bad++; $display("FAIL qz_done_cycle got=%0d exp=23", dc); end
    n_cmp++; if (crc5_run(bits[21:0], 22) !== 5'b00000) begin
      n_bad++; $display("FAIL qz_residue got=%b exp=00000", crc5_run(bits[21:0], 22));
    end
    n_cmp++; if (busy !== 1'b0 || out_vld !== 1'b0) begin
      n_bad++; $display("FAIL qz_done_state got busy=%b vld=%b exp 0 0", busy, out_vld);
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL qz_done_width got=%b exp=0", done); end
  endtask

  task automatic test_query_fields();
    logic [31:0] bits;
    int nb, li, nl, sb, vd, dc;
    logic [21:0] exp_f;
    clear_fields();
    dr = 1; m = 2'b11; q = 4'b1111;
    exp_f = {4'b1000, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 4'b1111, 5'b00000};
    exp_f[4:0] = crc5_run(exp_f, 17);
    send_start(2'b00);
    capture(0, 0, bits, nb, li, nl, sb, vd, dc);
    n_cmp++; if (bits[21:0] !== exp_f || nb !== 22) begin
      n_bad++; $display("FAIL qf_bits got=%b n=%0d exp=%b n=22", bits[21:0], nb, exp_f);
    end
    n_cmp++; if (crc5_run(bits[21:0], 22) !== 5'b00000) begin
      n_bad++; $display("FAIL qf_residue got=%b exp=00000", crc5_run(bits[21:0], 22));
    end
  endtask

  task automatic test_short_cmds();
    logic [31:0] bits;
    int nb, li, nl, sb, vd, dc;
    clear_fields();
    session = 2'b10;
    send_start(2'b01);
    capture(0, 0, bits, nb, li, nl, sb, vd, dc);
    n_cmp++; if (bits[3:0] !== 4'b0010 || nb !== 4) begin
      n_bad++; $display("FAIL rep_bits got=%b n=%0d exp=0010 n=4", bits[3:0], nb);
    end
    n_cmp++; if (li !== 4 || nl !== 1) begin n_bad++; $display("FAIL rep_last got idx=%0d cnt=%0d exp 4 1", li, nl); end
    n_cmp++; if (dc !== 5) begin n_bad++; $display("FAIL rep_done_cycle got=%0d exp=5", dc); end
    @(negedge clk);
    clear_fields();
    session = 2'b01; updn = 3'b110;
    send_start(2'b10);
    capture(0, 0, bits, nb, li, nl, sb, vd, dc);
    n_cmp++; if (bits[8:0] !== 9'b100101110 || nb !== 9) begin
      n_bad++; $display("FAIL adj_bits got=%b n=%0d exp=100101110 n=9", bits[8:0], nb);
    end
    n_cmp++; if (li !== 9 || nl !== 1) begin n_bad++; $display("FAIL adj_last got idx=%0d cnt=%0d exp 9 1", li, nl); end
    n_cmp++; if (dc !== 10) begin n_bad++; $display("FAIL adj_done_cycle got=%0d exp=10", dc); end
  endtask

  task automatic test_query_stall();
    logic [31:0] bits;
    int nb, li, nl, sb, vd, dc;
    logic [21:0] exp_f;
    clear_fields();
    trext = 1; sel = 2'b10; session = 2'b01; target = 1; q = 4'b0100;
    exp_f = {4'b1000, 1'b0, 2'b00, 1'b1, 2'b10, 2'b01, 1'b1, 4'b0100, 5'b00000};
    exp_f[4:0] = crc5_run(exp_f, 17);
    @(negedge clk);
    send_start(2'b00);
    capture(1, 0, bits, nb, li, nl, sb, vd, dc);
    n_cmp++; if (bits[21:0] !== exp_f || nb !== 22) begin
      n_bad++; $display("FAIL stall_bits got=%b n=%0d exp=%b n=22", bits[21:0], nb, exp_f);
    end
    n_cmp++; if (sb !== 0) begin n_bad++; $display("FAIL stall_stable got=%0d changes exp=0", sb); end
    n_cmp++; if (vd !== 0) begin n_bad++; $display("FAIL stall_vld_drop got=%0d exp=0", vd); end
    n_cmp++; if (li !== 22 || dc < 23) begin n_bad++; $display("FAIL stall_last got idx=%0d done=%0d exp idx=22 done>=23", li, dc); end
  endtask

  task automatic test_err_and_busy_start();
    logic [31:0] bits;
    int nb, li, nl, sb, vd, dc;
    logic [21:0] exp_f;
    clear_fields();
    @(negedge clk);
    send_start(2'b11);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_pulse got=%b exp=1", err); end
    n_cmp++; if (busy !== 1'b0 || out_vld !== 1'b0) begin
      n_bad++; $display("FAIL err_idle got busy=%b vld=%b exp 0 0", busy, out_vld);
    end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_width got=%b exp=0", err); end
    dr = 1; m = 2'b01; q = 4'b1010; session = 2'b10;
    exp_f = {4'b1000, 1'b1, 2'b01, 1'b0, 2'b00, 2'b10, 1'b0, 4'b1010, 5'b00000};
    exp_f[4:0] = crc5_run(exp_f, 17);
    send_start(2'b00);
    capture(0, 10, bits, nb, li, nl, sb, vd, dc);
    n_cmp++; if (bits[21:0] !== exp_f || nb !== 22) begin
      n_bad++; $display("FAIL busy_start_bits got=%b n=%0d exp=%b n=22", bits[21:0], nb, exp_f);
    end
    // A start during the DONE cycle must not launch a new frame.
    cmd = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (out_vld !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL done_start got vld=%b busy=%b exp 0 0", out_vld, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] bits;
    int nb, li, nl, sb, vd, dc;
    int n_done;
    logic [21:0] exp_f;
    clear_fields();
    @(negedge clk);
    send_start(2'b00);
    out_rdy = 1'b1;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (out_vld !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || out_dat !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_outputs got vld=%b busy=%b last=%b dat=%b exp 0 0 0 0", out_vld, busy, out_last, out_dat);
    end
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL rstmid_no_done got=%0d exp=0", n_done); end
    q = 4'b0101; sel = 2'b11; dr = 1;
    exp_f = {4'b1000, 1'b1, 2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 4'b0101, 5'b00000};
    exp_f[4:0] = crc5_run(exp_f, 17);
    send_start(2'b00);
    capture(0, 0, bits, nb, li, nl, sb, vd, dc);
    n_cmp++; if (bits[21:0] !== exp_f || nb !== 22) begin
      n_bad++; $display("FAIL rstmid_fresh got=%b n=%0d exp=%b n=22", bits[21:0], nb, exp_f);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cmd = 2'b00; out_rdy = 1'b0;
    clear_fields();
    test_reset();
    test_query_zero();
    test_query_fields();
    test_short_cmds();
    test_query_stall();
    test_err_and_busy_start();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
